// File: rtl/step_ctrl.sv
// Processor clock-enable sequencer: single step, fixed-length burst, free-running RUN
// at a divided rate, and a HALTED state that freezes everything while halt is high.
module step_ctrl #(
   parameter int RUN_DIV   = 25000000,
   parameter int BURST_LEN = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        step_pulse,
   input  logic        burst_pulse,
   input  logic        run_pulse,
   input  logic        halt,
   output logic        cpu_en,
   output logic [1:0]  mode,
   output logic [15:0] step_count
);

   localparam int DIV_W = $clog2(RUN_DIV);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RUN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
   localparam logic [7:0]       BURST_LOAD = 8'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BURST  = 2'b01,
      RUN    = 2'b10,
      HALTED = 2'b11
   } state_t;

   state_t           state, state_nxt;
   logic             en_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [7:0]       burst_cnt, burst_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cpu_en     <= 1'b0;
         div        <= '0;
         burst_cnt  <= '0;
         step_count <= '0;
      end else begin
         state     <= state_nxt;
         cpu_en    <= en_nxt;
         div       <= div_nxt;
         burst_cnt <= burst_nxt;
         if (cpu_en)
            step_count <= step_count + 16'd1;
      end
   end

   // burst_cnt holds enables still owed including the one issued this cycle;
   // the RUN enable is raised on the edge where the divider reaches zero.
   always_comb begin
      state_nxt = state;
      en_nxt    = 1'b0;
      div_nxt   = div;
      burst_nxt = burst_cnt;
      if (halt) begin
         state_nxt = HALTED;
      end else begin
         case (state)
            IDLE: begin
               if (run_pulse) begin
                  state_nxt = RUN;
                  div_nxt   = DIV_RELOAD;
               end else if (burst_pulse) begin
                  state_nxt = BURST;
                  burst_nxt = BURST_LOAD;
                  en_nxt    = 1'b1;
               end else if (step_pulse) begin
                  en_nxt = 1'b1;
               end
            end
            BURST: begin
               burst_nxt = burst_cnt - 8'd1;
               if (burst_cnt > 8'd1)
                  en_nxt = 1'b1;
               else
                  state_nxt = IDLE;
            end
            RUN: begin
               if (run_pulse) begin
                  state_nxt = IDLE;
               end else if (div == '0) begin
                  div_nxt = DIV_RELOAD;
               end else begin
                  div_nxt = div - DIV_ONE;
                  en_nxt  = (div == DIV_ONE);
               end
            end
            HALTED: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with RUN_DIV=4, BURST_LEN=3.
module tb_step_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        step_pulse, burst_pulse, run_pulse, halt;
   logic        cpu_en;
   logic [1:0]  mode;
   logic [15:0] step_count;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   step_ctrl #(.RUN_DIV(4), .BURST_LEN(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_pulse (step_pulse),
      .burst_pulse(burst_pulse),
      .run_pulse  (run_pulse),
      .halt       (halt),
      .cpu_en     (cpu_en),
      .mode       (mode),
      .step_count (step_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; step_pulse = 1'b0; burst_pulse = 1'b0; run_pulse = 1'b0; halt = 1'b0;
      exp_cnt = 16'd0;
      repeat (3) tick;
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got=%b want=0", cpu_en); end
      checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b want=00", mode); end
      checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", step_count); end
      #3 reset_n = 1'b1;
      tick; tick;
      checks++; if (mode !== 2'b00 || cpu_en !== 1'b0) begin errors++; $display("FAIL post_reset_idle mode=%b en=%b want 00/0", mode, cpu_en); end
   endtask

   task automatic test_step;
      step_pulse = 1'b1; tick; step_pulse = 1'b0;
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_en got=%b want=1", cpu_en); end
      checks++; if (mode !== 2'b00) begin errors++; $display("FAIL step_mode got=%b want=00", mode); end
      tick; exp_cnt++;
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL step_en_single got=%b want=0", cpu_en); end
      checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL step_count got=%0d want=%0d", step_count, exp_cnt); end
   endtask

   task automatic test_burst;
      burst_pulse = 1'b1; tick; burst_pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL burst_en[%0d] got=%b want=1", i, cpu_en); end
         checks++; if (mode !== 2'b01) begin errors++; $display("FAIL burst_mode[%0d] got=%b want=01", i, mode); end
         step_pulse = (i == 0);
         tick;
      end
      step_pulse = 1'b0;
      exp_cnt += 16'd3;
      checks++; if (mode !== 2'b00 || cpu_en !== 1'b0) begin errors++; $display("FAIL burst_end mode=%b en=%b want 00/0", mode, cpu_en); end
      checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL burst_count got=%0d want=%0d", step_count, exp_cnt); end
      tick;
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL burst_step_dropped en=%b want=0", cpu_en); end
   endtask

   task automatic test_run;
      run_pulse = 1'b1; tick; run_pulse = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         checks++; if (mode !== 2'b10) begin errors++; $display("FAIL run_mode[%0d] got=%b want=10", c, mode); end
         checks++; if (cpu_en !== ((c % 4) == 0)) begin errors++; $display("FAIL run_en[%0d] got=%b want=%b", c, cpu_en, ((c % 4) == 0)); end
         run_pulse = (c == 12);
         tick;
      end
      run_pulse = 1'b0;
      exp_cnt += 16'd3;
      checks++; if (mode !== 2'b00 || cpu_en !== 1'b0) begin errors++; $display("FAIL run_stop mode=%b en=%b want 00/0", mode, cpu_en); end
      checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL run_count got=%0d want=%0d", step_count, exp_cnt); end
      for (int c = 0; c < 6; c++) begin
         tick;
         checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL run_after_stop[%0d] en=%b want=0", c, cpu_en); end
      end
   endtask

   task automatic test_stop_on_expire;
      run_pulse = 1'b1; tick; run_pulse = 1'b0;
      tick; tick;
      run_pulse = 1'b1; tick; run_pulse = 1'b0;
      checks++; if (mode !== 2'b00 || cpu_en !== 1'b0) begin errors++; $display("FAIL stop_expire mode=%b en=%b want 00/0", mode, cpu_en); end
      tick;
      checks++; if (cpu_en !== 1'b0 || step_count !== exp_cnt) begin errors++; $display("FAIL stop_expire_after en=%b count=%0d want 0/%0d", cpu_en, step_count, exp_cnt); end
   endtask

   task automatic test_priority_halt;
      run_pulse = 1'b1; burst_pulse = 1'b1; step_pulse = 1'b1; tick;
      run_pulse = 1'b0; burst_pulse = 1'b0; step_pulse = 1'b0;
      checks++; if (mode !== 2'b10 || cpu_en !== 1'b0) begin errors++; $display("FAIL priority mode=%b en=%b want 10/0", mode, cpu_en); end
      tick;
      halt = 1'b1; tick;
      step_pulse = 1'b1; burst_pulse = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checks++; if (mode !== 2'b11 || cpu_en !== 1'b0) begin errors++; $display("FAIL halted[%0d] mode=%b en=%b want 11/0", c, mode, cpu_en); end
         tick;
      end
      burst_pulse = 1'b0; step_pulse = 1'b0;
      halt = 1'b0; tick;
      checks++; if (mode !== 2'b00 || cpu_en !== 1'b0) begin errors++; $display("FAIL unhalt mode=%b en=%b want 00/0", mode, cpu_en); end
      checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL halt_count got=%0d want=%0d", step_count, exp_cnt); end
      halt = 1'b1; step_pulse = 1'b1; tick;
      checks++; if (mode !== 2'b11 || cpu_en !== 1'b0) begin errors++; $display("FAIL halt_over_step mode=%b en=%b want 11/0", mode, cpu_en); end
      halt = 1'b0; tick; step_pulse = 1'b0;
      checks++; if (mode !== 2'b00 || cpu_en !== 1'b0) begin errors++; $display("FAIL halted_step_ignored mode=%b en=%b want 00/0", mode, cpu_en); end
   endtask

   task automatic test_wrap;
      int n;
      n = 65535 - int'(exp_cnt);
      step_pulse = 1'b1;
      repeat (n) tick;
      step_pulse = 1'b0;
      tick;
      checks++; if (step_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got=%h want=ffff", step_count); end
      step_pulse = 1'b1; tick; step_pulse = 1'b0;
      tick;
      exp_cnt = 16'd0;
      checks++; if (step_count !== 16'h0000) begin errors++; $display("FAIL wrap got=%h want=0000", step_count); end
   endtask

   task automatic test_reset_mid_burst;
      burst_pulse = 1'b1; tick; burst_pulse = 1'b0;
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL rst_burst_start en=%b want=1", cpu_en); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (cpu_en !== 1'b0 || mode !== 2'b00) begin errors++; $display("FAIL async_reset en=%b mode=%b want 0/00", cpu_en, mode); end
      checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL async_reset_count got=%0d want=0", step_count); end
      tick; tick;
      @(negedge clk);
      reset_n = 1'b1;
      tick;
      checks++; if (cpu_en !== 1'b0 || mode !== 2'b00) begin errors++; $display("FAIL burst_aborted en=%b mode=%b want 0/00", cpu_en, mode); end
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; step_pulse = 1'b1;
      tick; step_pulse = 1'b0;
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL first_edge_pulse en=%b want=1", cpu_en); end
      tick;
      checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL first_edge_count got=%0d want=1", step_count); end
   endtask

   initial begin
      test_reset;
      test_step;
      test_burst;
      test_run;
      test_stop_on_expire;
      test_priority_halt;
      test_wrap;
      test_reset_mid_burst;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
